// File: rtl/source_seq_pkg.sv
// source_seq_pkg: shared types and default widths for the transmit-burst
// sequencer (source_seq) and its per-channel strobe unit (source_seq_ch).
package source_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  localparam int DEF_CHANNEL = 3;
  localparam int DEF_PCMAW   = 10;
  localparam int DEF_DIVW    = 8;
  localparam int DEF_DLYW    = 12;
  localparam int DEF_GAPW    = 16;
  localparam int DEF_BCW     = 8;

endpackage

// File: rtl/source_seq_if.sv
// source_seq_if: control handshake plus the PCM source-memory read bus.
//   start/abort      : host -> sequencer trigger and stop request
//   busy/done        : sequencer status, done is a one-cycle pulse
//   burst_idx        : index of the burst in progress
//   pcm_out_valid    : memory -> sequencer, per-channel data present
//   signal_len       : per-channel waveform length (shared with memory)
//   pcm_out_ready    : sequencer -> memory, per-channel sample-read strobe
// Modports: master = sequencer side, slave = host/memory side.
interface source_seq_if #(
  parameter int CHANNEL = 3,
  parameter int pcmaw   = 10,
  parameter int BCW     = 8
);
  logic                     start;
  logic                     abort;
  logic                     busy;
  logic                     done;
  logic [BCW-1:0]           burst_idx;
  logic [CHANNEL-1:0]       pcm_out_valid;
  logic [CHANNEL-1:0]       pcm_out_ready;
  logic [pcmaw*CHANNEL-1:0] signal_len;

  modport master (
    input  start, abort, pcm_out_valid, signal_len,
    output busy, done, burst_idx, pcm_out_ready
  );

  modport slave (
    output start, abort, pcm_out_valid, signal_len,
    input  busy, done, burst_idx, pcm_out_ready
  );
endinterface

// File: rtl/source_seq_ch.sv
// source_seq_ch: one PCM channel of the burst sequencer.
// Counts `delay` ticks, then emits one registered ready strobe per tick
// until `len` samples have been requested.
//   pcm_clk, rst : clock, synchronous active-high reset
//   tick         : sample tick (already gated to PLAY by the parent)
//   clear        : zero both counters (burst start / burst end)
//   active       : channel takes part in this burst
//   delay, len   : latched start delay and sample count
//   ready        : one-clock read strobe to the source memory
//   finished     : channel has nothing more to send this burst
module source_seq_ch #(
  parameter int DLYW = 12,
  parameter int LENW = 10
) (
  input  logic            pcm_clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            clear,
  input  logic            active,
  input  logic [DLYW-1:0] delay,
  input  logic [LENW-1:0] len,
  output logic            ready,
  output logic            finished
);

  logic [DLYW-1:0] dly_cnt;
  logic [LENW-1:0] smp_cnt;

  always_ff @(posedge pcm_clk) begin
    if (rst) begin
      dly_cnt <= '0;
      smp_cnt <= '0;
      ready   <= 1'b0;
    end else if (clear) begin
      dly_cnt <= '0;
      smp_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (tick && active) begin
        if (dly_cnt != delay) begin
          dly_cnt <= dly_cnt + 1'b1;
        end else if (smp_cnt != len) begin
          ready   <= 1'b1;
          smp_cnt <= smp_cnt + 1'b1;
        end
      end
    end
  end

  // The final strobe is still on the wire while finished is already high,
  // so the parent leaves PLAY in the same clock the last strobe is seen.
  assign finished = !active || (smp_cnt == len);

endmodule

// File: rtl/source_seq.sv
// source_seq: transmit-burst sequencer for the multi-channel PCM source
// memory. A start trigger becomes a train of cfg_burst_cnt bursts; each
// burst plays signal_len samples per active channel after a per-channel
// tick delay, and bursts are separated by cfg_gap idle ticks. A burst is
// never cut short, so the memory always reaches its address wrap.
//   pcm_clk, rst   : sole clock, synchronous active-high reset
//   bus            : source_seq_if.master (start/abort/busy/done/burst_idx,
//                    pcm_out_valid/pcm_out_ready/signal_len)
//   cfg_div        : sample tick every cfg_div+1 clocks
//   cfg_burst_cnt  : number of bursts
//   cfg_gap        : idle ticks between bursts (0 = one clock)
//   ch_en          : channel enable mask
//   ch_delay       : per-channel start delay in ticks
// Build option SOURCE_SEQ_CONT_EN: cfg_burst_cnt==0 runs bursts until abort
// with burst_idx wrapping; without it cfg_burst_cnt==0 returns done at once.
module source_seq
  import source_seq_pkg::*;
#(
  parameter int CHANNEL = DEF_CHANNEL,
  parameter int pcmaw   = DEF_PCMAW,
  parameter int DIVW    = DEF_DIVW,
  parameter int DLYW    = DEF_DLYW,
  parameter int GAPW    = DEF_GAPW,
  parameter int BCW     = DEF_BCW
) (
  input  logic                    pcm_clk,
  input  logic                    rst,
  source_seq_if.master            bus,
  input  logic [DIVW-1:0]         cfg_div,
  input  logic [BCW-1:0]          cfg_burst_cnt,
  input  logic [GAPW-1:0]         cfg_gap,
  input  logic [CHANNEL-1:0]      ch_en,
  input  logic [DLYW*CHANNEL-1:0] ch_delay
);

  state_e                   state;
  logic [DIVW-1:0]          div_cnt, div_q;
  logic [GAPW-1:0]          gap_cnt, gap_q;
  logic [BCW-1:0]           bcnt_q, burst_idx;
  logic [DLYW*CHANNEL-1:0]  dly_q;
  logic [pcmaw*CHANNEL-1:0] len_q;
  logic [CHANNEL-1:0]       act_now, act_q, ch_fin, ch_rdy;
  logic                     done_q;

  logic tick, all_fin, play_end, ch_clear, ch_tick, last_burst, go;

  // Divider only runs while a burst train is in progress.
  assign tick     = (state != IDLE) && (div_cnt == div_q);
  assign ch_tick  = tick && (state == PLAY);
  assign all_fin  = &ch_fin;
  assign play_end = (state == PLAY) && all_fin;
  assign ch_clear = ((state == IDLE) && bus.start) || play_end;

`ifdef SOURCE_SEQ_CONT_EN
  // A zero burst count never reaches a last burst: run until abort.
  assign last_burst = (bcnt_q != '0) && (burst_idx == bcnt_q - 1'b1);
  assign go         = (act_now != '0);
`else
  assign last_burst = (burst_idx == bcnt_q - 1'b1);
  assign go         = (act_now != '0) && (cfg_burst_cnt != '0);
`endif

  for (genvar k = 0; k < CHANNEL; k++) begin : g_ch
    assign act_now[k] = ch_en[k] && bus.pcm_out_valid[k] &&
                        (bus.signal_len[k*pcmaw +: pcmaw] != '0);

    source_seq_ch #(.DLYW(DLYW), .LENW(pcmaw)) u_ch (
      .pcm_clk  (pcm_clk),
      .rst      (rst),
      .tick     (ch_tick),
      .clear    (ch_clear),
      .active   (act_q[k]),
      .delay    (dly_q[k*DLYW +: DLYW]),
      .len      (len_q[k*pcmaw +: pcmaw]),
      .ready    (ch_rdy[k]),
      .finished (ch_fin[k])
    );
  end

  always_ff @(posedge pcm_clk) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      div_q     <= '0;
      gap_cnt   <= '0;
      gap_q     <= '0;
      bcnt_q    <= '0;
      burst_idx <= '0;
      dly_q     <= '0;
      len_q     <= '0;
      act_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state != IDLE) div_cnt <= tick ? '0 : div_cnt + 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.start) begin
            div_q     <= cfg_div;
            gap_q     <= cfg_gap;
            bcnt_q    <= cfg_burst_cnt;
            dly_q     <= ch_delay;
            len_q     <= bus.signal_len;
            act_q     <= act_now;
            burst_idx <= '0;
            if (go) begin
              state   <= PLAY;
              div_cnt <= '0;
            end else begin
              done_q  <= 1'b1;
            end
          end
        end

        PLAY: begin
          // Abort is only looked at here, on a burst boundary.
          if (all_fin) begin
            if (!last_burst) burst_idx <= burst_idx + 1'b1;
            if (bus.abort || last_burst) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= '0;
            end
          end
        end

        GAP: begin
          if (bus.abort) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end else if (gap_q == '0) begin
            state   <= PLAY;
            div_cnt <= '0;
          end else if (tick) begin
            if (gap_cnt == gap_q - 1'b1) begin
              state   <= PLAY;
              div_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy          = (state != IDLE);
  assign bus.done          = done_q;
  assign bus.burst_idx     = burst_idx;
  assign bus.pcm_out_ready = ch_rdy;

endmodule

// File: tb/tb_source_seq.sv
module tb_source_seq;
  localparam int CH = 3, AW = 10, DIVW = 8, DLYW = 12, GAPW = 16, BCW = 8;
`ifdef SOURCE_SEQ_CONT_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic                pcm_clk = 1'b0;
  logic                rst = 1'b1;
  logic [DIVW-1:0]     cfg_div = '0;
  logic [BCW-1:0]      cfg_burst_cnt = '0;
  logic [GAPW-1:0]     cfg_gap = '0;
  logic [CH-1:0]       ch_en = '0;
  logic [DLYW*CH-1:0]  ch_delay = '0;

  source_seq_if #(.CHANNEL(CH), .pcmaw(AW), .BCW(BCW)) bus ();

  source_seq #(.CHANNEL(CH), .pcmaw(AW), .DIVW(DIVW), .DLYW(DLYW),
               .GAPW(GAPW), .BCW(BCW)) dut (
    .pcm_clk       (pcm_clk),
    .rst           (rst),
    .bus           (bus.master),
    .cfg_div       (cfg_div),
    .cfg_burst_cnt (cfg_burst_cnt),
    .cfg_gap       (cfg_gap),
    .ch_en         (ch_en),
    .ch_delay      (ch_delay)
  );

  always #5 pcm_clk = ~pcm_clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] rdy;
    logic          dn;
    logic [BCW-1:0] idx;
    logic          bsy;
  } ev_t;

  ev_t exp_q[$];
  int  n_vec = 0, n_err = 0, cyc = 0;

  // reference configuration for the current run
  int            m_div, m_n, m_gap;
  int            m_dly[CH], m_len[CH];
  logic [CH-1:0] m_en, m_vld;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge pcm_clk);
    #1;
    cyc++;
  endtask

  function automatic void push_ev(int c, logic [CH-1:0] r, logic d, int b, logic bs);
    ev_t e;
    e.cyc = c; e.rdy = r; e.dn = d; e.idx = BCW'(b); e.bsy = bs;
    exp_q.push_back(e);
  endfunction

  // Monitor: every clock with a strobe or done must match the next expected event.
  always @(negedge pcm_clk) begin
    if (!rst && (bus.pcm_out_ready != '0 || bus.done)) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL spurious_out: cycle %0d ready=%b done=%b, nothing expected",
                 cyc, bus.pcm_out_ready, bus.done);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_cycle", cyc, e.cyc);
        chk("ready_mask", bus.pcm_out_ready, e.rdy);
        chk("done", bus.done, e.dn);
        chk("burst_idx", bus.burst_idx, e.idx);
        chk("busy", bus.busy, e.bsy);
      end
    end
  end

  // Timeline from the rules: tick n of a burst starting at posedge Sb lands on
  // posedge Sb+n*(div+1); its strobe is seen that cycle. Burst ends after the
  // latest channel's delay+len ticks; done shows one clock after the last strobe.
  task automatic plan_run(input int S, input int mode, input int ab_b, input int ab_off,
                          output int ab_at, output int end_at);
    logic [CH-1:0] act, msk;
    int T, Sb, E, Q, m0;
    bit last;
    act = '0; T = 0; ab_at = -1; end_at = S;
    for (int k = 0; k < CH; k++) begin
      act[k] = m_en[k] && m_vld[k] && (m_len[k] != 0);
      if (act[k] && (m_dly[k] + m_len[k] > T)) T = m_dly[k] + m_len[k];
    end
    if (act == '0 || (m_n == 0 && !CONT)) begin
      push_ev(S, '0, 1'b1, 0, 1'b0);
      return;
    end
    Sb = S;
    for (int b = 0; b < 2000; b++) begin
      for (int n = 1; n <= T; n++) begin
        msk = '0;
        for (int k = 0; k < CH; k++)
          msk[k] = act[k] && (n > m_dly[k]) && (n <= m_dly[k] + m_len[k]);
        if (msk != '0) push_ev(Sb + n*(m_div+1), msk, 1'b0, b, 1'b1);
      end
      E = Sb + T*(m_div+1) + 1;
      last = (m_n != 0) && (b == m_n - 1);
      if (mode == 1 && b == ab_b) ab_at = Sb + ab_off % (E - Sb);
      if (last || (mode == 1 && b == ab_b)) begin
        push_ev(E, '0, 1'b1, last ? b : b + 1, 1'b0);
        end_at = E;
        return;
      end
      if (m_gap == 0) Q = E + 1;
      else begin
        m0 = (m_div == 0) ? T + 2 : T + 1;
        Q = Sb + (m0 + m_gap - 1)*(m_div+1);
      end
      if (mode == 2 && b == ab_b) begin
        ab_at = E + ab_off % (Q - E);
        push_ev(ab_at + 1, '0, 1'b1, b + 1, 1'b0);
        end_at = ab_at + 1;
        return;
      end
      Sb = Q;
    end
  endtask

  task automatic drive_cfg();
    cfg_div = DIVW'(m_div);
    cfg_burst_cnt = BCW'(m_n);
    cfg_gap = GAPW'(m_gap);
    ch_en = m_en;
    bus.pcm_out_valid = m_vld;
    for (int k = 0; k < CH; k++) begin
      ch_delay[k*DLYW +: DLYW] = DLYW'(m_dly[k]);
      bus.signal_len[k*AW +: AW] = AW'(m_len[k]);
    end
  endtask

  task automatic run(input int mode, input int ab_b, input int ab_off);
    int S, ab_at, end_at, pk;
    drive_cfg();
    bus.start = 1'b1;
    S = cyc + 1;
    plan_run(S, mode, ab_b, ab_off, ab_at, end_at);
    step();
    // configuration must be held internally: scramble the live inputs
    cfg_div = DIVW'($urandom); cfg_burst_cnt = BCW'($urandom);
    cfg_gap = GAPW'($urandom); ch_en = CH'($urandom);
    ch_delay = {$urandom, $urandom}; bus.pcm_out_valid = CH'($urandom);
    bus.signal_len = {$urandom};
    pk = (end_at - S >= 2) ? S + int'($urandom_range(0, end_at - S - 2)) : -1;
    while (cyc < end_at + 2) begin
      bus.abort = (ab_at >= 0) && (cyc >= ab_at) && (cyc < end_at);
      bus.start = (cyc == pk);   // start while busy must be ignored
      step();
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("events_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic set_all(input int dly, input int len);
    for (int k = 0; k < CH; k++) begin m_dly[k] = dly; m_len[k] = len; end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int mode, ab_b;
    bus.start = 1'b0; bus.abort = 1'b0; bus.pcm_out_valid = '0; bus.signal_len = '0;
    repeat (3) step();
    chk("rst_ready", bus.pcm_out_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_idx", bus.burst_idx, 0);
    rst = 1'b0;
    step();

    // single burst, strobes two clocks apart
    m_div = 1; m_n = 1; m_gap = 0; m_en = '1; m_vld = '1; set_all(0, 4);
    run(0, 0, 0);
    chk("idle_busy", bus.busy, 0);
    // steering
    m_div = 0; set_all(0, 8); m_dly[1] = 2; m_dly[2] = 5;
    run(0, 0, 0);
    // train with gap
    m_n = 3; m_gap = 10; set_all(1, 4);
    run(0, 0, 0);
    // abort mid-PLAY of burst 0 of 5, then abort in GAP after burst 1
    m_n = 5; m_gap = 4; set_all(0, 3);
    run(1, 0, 3);
    run(2, 1, 2);
    // no enabled channel; zero-length channel 1
    m_n = 2; m_en = '0;
    run(0, 0, 0);
    m_en = '1; m_len[1] = 0; m_dly[2] = 3;
    run(0, 0, 0);
    // zero burst count
    set_all(0, 1); m_gap = 0; m_div = 0; m_n = 0;
    if (CONT) run(1, 305, 0);
    else run(0, 0, 0);

    // reset during burst 1: T=2, gap 0 -> burst 1 strobes at S+5, S+6
    m_n = 3; m_gap = 0; m_div = 0; set_all(0, 2);
    begin
      int S, ab_at, end_at;
      drive_cfg();
      bus.start = 1'b1;
      S = cyc + 1;
      plan_run(S, 0, 0, 0, ab_at, end_at);
      step();
      bus.start = 1'b0;
      while (cyc < S + 5) step();
      chk("mid_busy", bus.busy, 1);
      chk("mid_idx", bus.burst_idx, 1);
      rst = 1'b1;
      step();
      chk("rst_mid_ready", bus.pcm_out_ready, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_done", bus.done, 0);
      chk("rst_mid_idx", bus.burst_idx, 0);
      exp_q.delete();
      rst = 1'b0;
      step();
    end

    for (int r = 0; r < 40; r++) begin
      m_div = $urandom_range(0, 3);
      m_gap = $urandom_range(0, 5);
      m_n   = $urandom_range(0, 4);
      m_en  = CH'($urandom);
      m_vld = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '1;
      for (int k = 0; k < CH; k++) begin
        m_dly[k] = $urandom_range(0, 6);
        m_len[k] = $urandom_range(0, 6);
      end
      mode = $urandom_range(0, 2);
      ab_b = $urandom_range(0, (m_n > 0) ? m_n - 1 : 3);
      if (CONT && m_n == 0 && mode == 0) mode = 1;
      run(mode, ab_b, $urandom_range(0, 1000));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/source_seq.md
Name: source_seq

Overview:
- Transmit-burst sequencer that drives the per-channel pcm_out_ready strobes of the multi-channel PCM source memory.
- Converts a start trigger into a train of bursts. Each burst is exactly signal_len samples per enabled channel, with a per-channel start delay for beam steering, a programmable sample-rate divider and an inter-burst gap.
- Bursts always end on the memory's address wrap, so every burst replays the waveform from address 0.

Parameters:
- CHANNEL, 3, number of PCM channels.
- pcmaw, 10, PCM memory address width; also the width of each signal_len field.
- DIVW, 8, sample-divider width.
- DLYW, 12, per-channel delay width, counted in sample ticks.
- GAPW, 16, inter-burst gap width, counted in sample ticks.
- BCW, 8, burst-count width.

Ports:
- pcm_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle trigger; accepted only in IDLE.
- abort  in  1  level; stop at the next burst boundary.
- cfg_div  in  DIVW  sample tick every cfg_div+1 clocks.
- cfg_burst_cnt  in  BCW  number of bursts; 0 means none.
- cfg_gap  in  GAPW  idle ticks between bursts.
- ch_en  in  CHANNEL  channel enable mask.
- ch_delay  in  DLYW*CHANNEL  per-channel start delay in ticks.
- signal_len  in  pcmaw*CHANNEL  per-channel sample count; same bus as the source memory.
- pcm_out_valid  in  CHANNEL  from the source memory.
- pcm_out_ready  out  CHANNEL  sample-read strobe to the source memory.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on return to IDLE.
- burst_idx  out  BCW  index of the current burst, starting at 0.

Behaviour:
- Reset: all outputs 0; state IDLE; every counter 0.
- Configuration is latched on the start-accept cycle and held stable until IDLE.
- Active channel = ch_en[k] && pcm_out_valid[k] && signal_len[k]!=0, evaluated at latch time.
- Tick divider: free-running only while state is PLAY or GAP. It restarts at 0 on entry to PLAY. With cfg_div=0 a tick occurs every clock.
- IDLE → PLAY when start && cfg_burst_cnt!=0 && at least one channel is active.
- IDLE → done pulse, staying in IDLE, when start arrives with no active channel or cfg_burst_cnt==0.
- PLAY, per-channel counters:
  - dly_cnt[k] counts ticks up to ch_delay[k].
  - Once dly_cnt[k] reaches ch_delay[k], each tick asserts pcm_out_ready[k] for exactly 1 clock and increments smp_cnt[k].
  - After smp_cnt[k]==signal_len[k] the channel issues no further strobes.
  - A strobe is registered: pcm_out_ready rises the clock after the tick.
  - Inactive channels never strobe.
- PLAY → GAP when all active channels are finished and further bursts remain and abort is low.
- PLAY → IDLE (done pulse) when all active channels are finished and either this was the last burst or abort is high.
- On each PLAY exit, every dly_cnt and smp_cnt clears and burst_idx increments.
- GAP lasts cfg_gap ticks; cfg_gap=0 means GAP lasts 1 clock. GAP → PLAY afterwards.
- abort seen in GAP → IDLE immediately (done pulse).
- abort is never honoured mid-PLAY. This preserves the memory address wrap.
- start in any non-IDLE state is ignored.
- Counter widths: smp_cnt is pcmaw bits and compares against signal_len exactly. burst_idx saturates at cfg_burst_cnt-1.
- rst asserted mid-burst: immediate return to IDLE with no done pulse. The memory shares rst, so its addresses also return to 0.

Optional Feature:
- Macro: SOURCE_SEQ_CONT_EN.
- Defined: cfg_burst_cnt==0 means continuous operation. Bursts repeat until abort, and burst_idx wraps modulo 2^BCW.
- Undefined: cfg_burst_cnt==0 means no bursts; start yields an immediate done pulse.

Decomposition:
- Package source_seq_pkg:
  - State enum: IDLE, PLAY, GAP.
  - Default widths: DIVW, DLYW, GAPW, BCW.
- Sub-module source_seq_ch, instantiated CHANNEL times:
  - Contains the delay counter, sample counter and strobe register.
  - Inputs: tick, clear, active, delay, len.
  - Outputs: ready, finished.

Test Plan:
- Single burst: cfg_div=1, ch_delay=0, signal_len=4 on all channels, cfg_burst_cnt=1 → exactly 4 ready strobes per channel, 2 clocks apart. Then done pulse, busy low.
- Steering: ch_delay={0,2,5}, signal_len=8, cfg_div=0 → channel k strobes start 0/2/5 clocks after channel 0. PLAY ends after the 13th tick; 8 strobes per channel.
- Train: cfg_burst_cnt=3, cfg_gap=10 → burst_idx steps 0,1,2. 10 strobe-free ticks between bursts. Total strobes = 3×signal_len.
- Abort: abort raised mid-PLAY of burst 0 of 5 → burst 0 completes fully, then IDLE with done. Abort raised in GAP → IDLE next clock.
- Boundaries:
  - ch_en=0 → immediate done.
  - signal_len[1]=0 → channel 1 never strobes.
  - start while busy → ignored.
  - rst mid-PLAY → all outputs 0 the next clock.
- With SOURCE_SEQ_CONT_EN and cfg_burst_cnt=0 → bursts continue past 300 bursts with burst_idx wrapping at 256; abort then stops at a burst boundary.
